fft_butterfly_stage3: RTL and testbench
=======================================

Name: fft_butterfly_stage3

Overview:
- Final radix-2 DIF stage of the 8-point FFT. Sits directly downstream of fft_butterfly_stage2 and consumes its 8-sample frames.
- Computes the span-1 butterflies. All stage-3 twiddles are W8^0 = 1, so the datapath has no multiplier.
- Writes results into a ping-pong frame buffer at bit-reversed addresses, so output frames stream in natural bin order X[0..7].
- Uses the same valid/ready streaming handshake as stage 2.

Parameters:
- DATA_WIDTH, 50: packed complex sample width. Upper DATA_WIDTH/2 bits are signed re; lower DATA_WIDTH/2 bits are signed im.
- SCALE, 0: 0 = sums/differences wrap modulo 2^(DATA_WIDTH/2); 1 = each result is arithmetically shifted right by 1 (floor), computed at full precision first.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- signal_i  in  DATA_WIDTH  input sample {re, im}, frame order x[0..7]
- valid_i  in  1  signal_i valid
- ready_o  out  1  block can accept signal_i
- signal_o  out  DATA_WIDTH  output bin {re, im}, natural order X[0..7]
- valid_o  out  1  signal_o valid
- ready_i  in  1  downstream accepts signal_o
- last_o  out  1  high with valid_o when X[7] is presented

Behaviour:
- Clock and reset: clk_i rising edge; rst_i asynchronous, active-high.
- Reset clears: in_cnt, out_cnt, wr_sel, rd_sel, full[1:0], even_hold. Bank contents are not cleared.
- Output values during/after reset: valid_o=0, last_o=0, signal_o=0. ready_o=0 while rst_i is high and 1 from the first cycle after release.
- Transfer rule: an input transfer is valid_i && ready_o at a clk edge; an output transfer is valid_o && ready_i.
- ready_o = !rst_i && !full[wr_sel]. This is combinational, with no dependency on valid_i.
- Input counter: in_cnt (3b) increments on each input transfer and wraps 7->0.
- Even sample (in_cnt even): signal_i is stored in even_hold.
- Odd sample (in_cnt = 2k+1), written on the same edge into bank[wr_sel]:
  - a = even_hold, b = signal_i; re and im are processed independently.
  - s = a+b and d = a-b, each computed at DATA_WIDTH/2+1 bits.
  - SCALE=0: keep the low DATA_WIDTH/2 bits. SCALE=1: keep s>>>1 and d>>>1.
  - s goes to address bitrev3(2k); d goes to address bitrev3(2k+1).
  - Resulting address pairs: k=0 -> 0,4; k=1 -> 2,6; k=2 -> 1,5; k=3 -> 3,7.
- Frame complete: on the transfer with in_cnt=7, full[wr_sel] is set and wr_sel toggles on the same edge.
- Output read: valid_o = full[rd_sel] and signal_o = bank[rd_sel][out_cnt], both combinational from registers.
  - When valid_o=0, signal_o=0.
  - last_o = valid_o && out_cnt==7.
- Output counter: out_cnt increments on each output transfer. On the transfer with out_cnt=7: full[rd_sel] is cleared, rd_sel toggles, out_cnt returns to 0.
- Latency: X[0] is valid on the cycle after the edge that accepts x[7]. With ready_i=1, all 8 outputs stream on consecutive cycles.
- Throughput: one sample per cycle in and out, sustained. The ping-pong lets frame n+1 fill while frame n drains.
- Backpressure:
  - While valid_o && !ready_i, signal_o, last_o and out_cnt hold.
  - With both banks full, ready_o=0 and input stalls mid-gap. Partial-frame state (in_cnt, even_hold) is retained.
- Simultaneous events: completing a fill of one bank and a drain of the other on the same edge are independent and both take effect.
  - Fill-complete and drain-complete on the same bank on the same edge is impossible, because a bank is never written while full.
- Input stall: a gap in valid_i between even and odd samples is legal; even_hold persists.
- Reset mid-operation: any partial input frame and any pending output frames are discarded. The first input after release is treated as x[0].

Test Plan:
- Impulse x[0]=(1,0), x[1..7]=0, SCALE=0, ready_i=1 -> X[0]=(1,0), X[4]=(1,0), all others 0. X[0] valid 1 cycle after x[7] accepted; last_o only on X[7].
- Ramp x[k]=(k,0), SCALE=0 -> X[0..7] re = 1,9,5,13,-1,-1,-1,-1; im all 0.
- Overflow x[0]=x[1]=(2^24-1, -2^24), rest 0:
  - SCALE=0 -> X[0]=(-2, 0), X[4]=(0,0).
  - SCALE=1 -> X[0]=(2^24-1, -2^24), X[4]=(0,0).
- Backpressure: three back-to-back frames with ready_i=0 -> ready_o drops after the 16th sample accepted. Then release ready_i=1 -> 24 outputs in order with no loss or duplication.
- Throttled: random valid_i/ready_i gaps, including a gap between even and odd samples -> outputs match the reference model bit-exactly.
- Reset mid-drain: assert rst_i at out_cnt=3 -> valid_o=0 and signal_o=0 immediately. A new frame afterwards is processed correctly from x[0].

Source files
------------

// File: rtl/fft_butterfly_stage3.sv
// Final radix-2 DIF stage of the 8-point FFT: span-1 add/subtract butterflies
// written bit-reversed into a ping-pong frame buffer so bins leave in natural order.
module fft_butterfly_stage3 #(
    parameter int DATA_WIDTH = 50,
    parameter bit SCALE      = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] signal_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] signal_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o
);

    localparam int H = DATA_WIDTH / 2;

    logic [2:0]            r_in_cnt;
    logic [2:0]            r_out_cnt;
    logic                  r_wr_sel;
    logic                  r_rd_sel;
    logic [1:0]            r_full;
    logic [DATA_WIDTH-1:0] r_even_hold;
    logic [DATA_WIDTH-1:0] r_bank [0:1][0:7];

    logic                  w_in_xfer;
    logic                  w_out_xfer;
    logic                  w_in_last;
    logic                  w_out_last;
    logic [1:0]            w_full_nxt;

    logic signed [H:0]     w_a_re;
    logic signed [H:0]     w_a_im;
    logic signed [H:0]     w_b_re;
    logic signed [H:0]     w_b_im;
    logic signed [H:0]     w_sum_re;
    logic signed [H:0]     w_sum_im;
    logic signed [H:0]     w_dif_re;
    logic signed [H:0]     w_dif_im;
    logic [DATA_WIDTH-1:0] w_sum;
    logic [DATA_WIDTH-1:0] w_dif;
    logic [2:0]            w_addr_s;
    logic [2:0]            w_addr_d;

    // Full-precision result narrowed back to H bits: wrap or floor-halve.
    function automatic logic [H-1:0] f_pick(input logic [H:0] v);
        if (SCALE) begin
            return v[H:1];
        end
        return v[H-1:0];
    endfunction

    assign ready_o    = !rst_i && !r_full[r_wr_sel];
    assign w_in_xfer  = valid_i && ready_o;
    assign w_out_xfer = valid_o && ready_i;
    assign w_in_last  = w_in_xfer && (r_in_cnt == 3'd7);
    assign w_out_last = w_out_xfer && (r_out_cnt == 3'd7);

    assign w_a_re   = {r_even_hold[DATA_WIDTH-1], r_even_hold[DATA_WIDTH-1:H]};
    assign w_a_im   = {r_even_hold[H-1], r_even_hold[H-1:0]};
    assign w_b_re   = {signal_i[DATA_WIDTH-1], signal_i[DATA_WIDTH-1:H]};
    assign w_b_im   = {signal_i[H-1], signal_i[H-1:0]};
    assign w_sum_re = w_a_re + w_b_re;
    assign w_sum_im = w_a_im + w_b_im;
    assign w_dif_re = w_a_re - w_b_re;
    assign w_dif_im = w_a_im - w_b_im;
    assign w_sum    = {f_pick(w_sum_re), f_pick(w_sum_im)};
    assign w_dif    = {f_pick(w_dif_re), f_pick(w_dif_im)};

    // With in_cnt = 2k+1, k = in_cnt[2:1]; bitrev3(2k) = {0,k[0],k[1]}, bitrev3(2k+1) = {1,k[0],k[1]}.
    assign w_addr_s = {1'b0, r_in_cnt[1], r_in_cnt[2]};
    assign w_addr_d = {1'b1, r_in_cnt[1], r_in_cnt[2]};

    // Fill of one bank and drain of the other can land on the same edge.
    always_comb begin
        w_full_nxt = r_full;
        if (w_in_last) begin
            w_full_nxt[r_wr_sel] = 1'b1;
        end
        if (w_out_last) begin
            w_full_nxt[r_rd_sel] = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_wr_sel    <= 1'b0;
            r_rd_sel    <= 1'b0;
            r_full      <= '0;
            r_even_hold <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_in_xfer) begin
                r_in_cnt <= r_in_cnt + 3'd1;
                if (!r_in_cnt[0]) begin
                    r_even_hold <= signal_i;
                end
            end
            if (w_in_last) begin
                r_wr_sel <= ~r_wr_sel;
            end
            if (w_out_xfer) begin
                r_out_cnt <= r_out_cnt + 3'd1;
            end
            if (w_out_last) begin
                r_rd_sel <= ~r_rd_sel;
            end
        end
    end

    // Bank storage carries no reset; the full flags alone qualify its contents.
    always_ff @(posedge clk_i) begin
        if (w_in_xfer && r_in_cnt[0]) begin
            r_bank[r_wr_sel][w_addr_s] <= w_sum;
            r_bank[r_wr_sel][w_addr_d] <= w_dif;
        end
    end

    assign valid_o  = r_full[r_rd_sel];
    assign signal_o = valid_o ? r_bank[r_rd_sel][r_out_cnt] : '0;
    assign last_o   = valid_o && (r_out_cnt == 3'd7);

endmodule

// File: tb/tb_fft_butterfly_stage3.sv
// Directed bench for fft_butterfly_stage3: two instances (wrap and halving) share the
// input stream; outputs are compared against hand-computed bins and a small integer model.
module tb_fft_butterfly_stage3;

    localparam int DW = 50;
    localparam int H  = DW / 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] signal_i;
    logic          valid_i;
    logic          ready_i;
    logic          ready_o;
    logic [DW-1:0] signal_o;
    logic          valid_o;
    logic          last_o;
    logic          ready_o_s;
    logic [DW-1:0] signal_o_s;
    logic          valid_o_s;
    logic          last_o_s;

    fft_butterfly_stage3 #(.DATA_WIDTH(DW), .SCALE(1'b0)) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .signal_i(signal_i), .valid_i(valid_i),
        .ready_o(ready_o), .signal_o(signal_o), .valid_o(valid_o),
        .ready_i(ready_i), .last_o(last_o)
    );

    fft_butterfly_stage3 #(.DATA_WIDTH(DW), .SCALE(1'b1)) u_dut_s (
        .clk_i(clk_i), .rst_i(rst_i), .signal_i(signal_i), .valid_i(valid_i),
        .ready_o(ready_o_s), .signal_o(signal_o_s), .valid_o(valid_o_s),
        .ready_i(ready_i), .last_o(last_o_s)
    );

    always #5 clk_i = ~clk_i;

    int            checks   = 0;
    int            failures = 0;
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] exp0_q[$];
    logic [DW-1:0] exp1_q[$];
    int            out_idx = 0;
    int            cyc = 0;
    int            n_acc = 0;
    int            last_acc_cyc = 0;
    int            first_out_cyc = -1;
    int            last_out_cyc = 0;
    int            brv[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [DW-1:0] pk(input longint re, input longint im);
        logic [63:0] r;
        logic [63:0] i;
        r = re;
        i = im;
        return {r[H-1:0], i[H-1:0]};
    endfunction

    function automatic logic [DW-1:0] bf(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input bit sub, input bit scale);
        longint ar, ai, br, bi, rr, ri;
        ar = longint'(signed'(a[DW-1:H]));
        ai = longint'(signed'(a[H-1:0]));
        br = longint'(signed'(b[DW-1:H]));
        bi = longint'(signed'(b[H-1:0]));
        rr = sub ? ar - br : ar + br;
        ri = sub ? ai - bi : ai + bi;
        if (scale) begin
            rr = rr >>> 1;
            ri = ri >>> 1;
        end
        return pk(rr, ri);
    endfunction

    task automatic push_model_frame(input logic [DW-1:0] x[8]);
        logic [DW-1:0] o0[8];
        logic [DW-1:0] o1[8];
        for (int k = 0; k < 4; k++) begin
            o0[brv[2*k]]   = bf(x[2*k], x[2*k+1], 1'b0, 1'b0);
            o0[brv[2*k+1]] = bf(x[2*k], x[2*k+1], 1'b1, 1'b0);
            o1[brv[2*k]]   = bf(x[2*k], x[2*k+1], 1'b0, 1'b1);
            o1[brv[2*k+1]] = bf(x[2*k], x[2*k+1], 1'b1, 1'b1);
        end
        for (int n = 0; n < 8; n++) begin
            in_q.push_back(x[n]);
            exp0_q.push_back(o0[n]);
            exp1_q.push_back(o1[n]);
        end
    endtask

    task automatic step(input bit vi, input bit ri);
        @(negedge clk_i);
        valid_i  = vi && (in_q.size() > 0);
        signal_i = (in_q.size() > 0) ? in_q[0] : '0;
        ready_i  = ri;
        #1;
        cyc++;
        if (valid_i && ready_o) begin
            void'(in_q.pop_front());
            n_acc++;
            if (n_acc % 8 == 0) last_acc_cyc = cyc;
        end
        if (valid_o && ready_i) begin
            if (first_out_cyc < 0) first_out_cyc = cyc;
            last_out_cyc = cyc;
            if (exp0_q.size() == 0) begin
                check_eq("extra_out", 64'(valid_o), 64'd0);
            end else begin
                check_eq("bin_wrap", 64'(signal_o), 64'(exp0_q.pop_front()));
                check_eq("bin_half", 64'(signal_o_s), 64'(exp1_q.pop_front()));
                check_eq("last", 64'(last_o), 64'(out_idx == 7));
            end
            out_idx = (out_idx + 1) % 8;
        end
    endtask

    task automatic run(input int vp, input int rp, input int budget);
        int t = 0;
        while ((in_q.size() > 0 || exp0_q.size() > 0) && t < budget) begin
            step($urandom_range(99) < vp, $urandom_range(99) < rp);
            t++;
        end
        check_eq("drained", 64'(in_q.size() + exp0_q.size()), 64'd0);
    endtask

    logic [DW-1:0] fr[8];
    int            ramp0[8] = '{1, 9, 5, 13, -1, -1, -1, -1};
    int            ramp1[8] = '{0, 4, 2, 6, -1, -1, -1, -1};
    int            acc0;

    initial begin
        rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b0; signal_i = '0;
        repeat (2) @(negedge clk_i);
        check_eq("rst_valid", 64'(valid_o), 64'd0);
        check_eq("rst_last", 64'(last_o), 64'd0);
        check_eq("rst_signal", 64'(signal_o), 64'd0);
        check_eq("rst_ready", 64'(ready_o), 64'd0);
        rst_i = 1'b0;
        @(negedge clk_i);
        check_eq("post_rst_ready", 64'(ready_o), 64'd1);

        // Impulse: X[0] = X[4] = (1,0); halving gives all zeros.
        for (int n = 0; n < 8; n++) begin
            in_q.push_back(n == 0 ? pk(1, 0) : '0);
            exp0_q.push_back((n == 0 || n == 4) ? pk(1, 0) : '0);
            exp1_q.push_back('0);
        end
        first_out_cyc = -1;
        run(100, 100, 60);
        check_eq("latency", 64'(first_out_cyc - last_acc_cyc), 64'd1);
        check_eq("burst", 64'(last_out_cyc - first_out_cyc), 64'd7);

        // Ramp x[k] = (k,0).
        for (int n = 0; n < 8; n++) begin
            in_q.push_back(pk(n, 0));
            exp0_q.push_back(pk(ramp0[n], 0));
            exp1_q.push_back(pk(ramp1[n], 0));
        end
        run(100, 100, 60);

        // Overflow pair at the extremes of the 25-bit range.
        for (int n = 0; n < 8; n++) begin
            in_q.push_back(n < 2 ? pk(2**24 - 1, -(2**24)) : '0);
            exp0_q.push_back(n == 0 ? pk(-2, 0) : '0);
            exp1_q.push_back(n == 0 ? pk(2**24 - 1, -(2**24)) : '0);
        end
        run(100, 100, 60);

        // Backpressure: three frames against a stalled sink.
        for (int f = 0; f < 3; f++) begin
            for (int n = 0; n < 8; n++) fr[n] = pk(100 * f + n, -(10 * f + n));
            push_model_frame(fr);
        end
        acc0 = n_acc;
        repeat (30) step(1'b1, 1'b0);
        check_eq("bp_accepted", 64'(n_acc - acc0), 64'd16);
        check_eq("bp_ready_low", 64'(ready_o), 64'd0);
        check_eq("bp_valid_held", 64'(valid_o), 64'd1);
        run(100, 100, 200);

        // Throttled traffic with a forced even/odd gap at the start.
        for (int f = 0; f < 4; f++) begin
            for (int n = 0; n < 8; n++) fr[n] = DW'({$urandom(), $urandom()});
            push_model_frame(fr);
        end
        step(1'b1, 1'b1);
        repeat (3) step(1'b0, 1'b1);
        run(60, 60, 1500);

        // Reset mid-drain with a partial second frame pending.
        for (int n = 0; n < 8; n++) fr[n] = pk(n, 0);
        push_model_frame(fr);
        repeat (8) step(1'b1, 1'b0);
        for (int n = 0; n < 8; n++) in_q.push_back(pk(7, 7));
        repeat (3) step(1'b1, 1'b0);
        repeat (3) step(1'b0, 1'b1);
        @(negedge clk_i);
        valid_i = 1'b0;
        ready_i = 1'b1;
        rst_i   = 1'b1;
        #1;
        check_eq("mid_rst_valid", 64'(valid_o), 64'd0);
        check_eq("mid_rst_signal", 64'(signal_o), 64'd0);
        check_eq("mid_rst_ready", 64'(ready_o), 64'd0);
        in_q.delete();
        exp0_q.delete();
        exp1_q.delete();
        out_idx = 0;
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        check_eq("rel_valid", 64'(valid_o), 64'd0);
        for (int n = 0; n < 8; n++) begin
            in_q.push_back(n == 0 ? pk(3, -5) : '0);
            exp0_q.push_back((n == 0 || n == 4) ? pk(3, -5) : '0);
            exp1_q.push_back((n == 0 || n == 4) ? pk(1, -3) : '0);
        end
        run(100, 100, 60);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
